// File: rtl/system_nios2_ocimem_sequencer.sv
// JTAG-driven sequencer for the Nios II on-chip debug memory.
// Turns debug command pulses into single-word reads/writes with wait/timeout handling.
module system_nios2_ocimem_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       mond_q, mond_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              any_cmd;
    logic              unused_jdo;

    assign any_cmd    = take_action_ocimem_a | take_action_ocimem_b |
                        take_no_action_ocimem_a;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mond_d  = mond_q;
        wdata_d = wdata_q;
        read_d  = read_q;
        write_d = write_q;
        ready_d = ready_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_cmd && !debugack) begin
                    err_d = 1'b1;
                end else if (take_action_ocimem_b) begin
                    mond_d  = jdo[34:3];
                    wdata_d = jdo[34:3];
                    state_d = S_WRITE;
                    write_d = 1'b1;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    wcnt_d  = 8'd0;
                end else if (take_action_ocimem_a) begin
                    addr_d = jdo[17 +: ADDR_W];
                    if (jdo[34]) begin
                        state_d = S_READ;
                        read_d  = 1'b1;
                        ready_d = 1'b0;
                        err_d   = 1'b0;
                        wcnt_d  = 8'd0;
                    end
                end else if (take_no_action_ocimem_a) begin
                    state_d = S_READ;
                    read_d  = 1'b1;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    wcnt_d  = 8'd0;
                end
            end
            S_READ, S_WRITE: begin
                if (any_cmd) begin
                    err_d = 1'b1;
                end
                if (!mem_waitrequest) begin
                    if (state_q == S_READ) begin
                        mond_d = mem_readdata;
                    end
                    state_d = S_IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    ready_d = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                    // Last allowed stall cycle: give up, keep addr and MonDReg.
                    if (wcnt_q == WAIT_LAST) begin
                        state_d = S_IDLE;
                        read_d  = 1'b0;
                        write_d = 1'b0;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            mond_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            wcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mond_q  <= mond_d;
            wdata_q <= wdata_d;
            read_q  <= read_d;
            write_q <= write_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign mem_address   = addr_q;
    assign mem_read      = read_q;
    assign mem_write     = write_q;
    assign mem_writedata = wdata_q;
    assign MonDReg       = mond_q;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;

endmodule
